// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared front-end widths and the instruction buffer entry type
package inst_buffer_pkg;

    localparam int FETCH_WIDTH  = 4;
    localparam int DECODE_WIDTH = 4;
    localparam int IBUF_DEPTH   = 16;
    localparam int XLEN         = 32;
    localparam int INST_WIDTH   = 32;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_WIDTH-1:0] inst;
    } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// rtl/inst_buffer_if.sv - fetch-to-decode instruction buffer bus, fetch/decode side as master
interface inst_buffer_if #(
    parameter int FW = inst_buffer_pkg::FETCH_WIDTH,
    parameter int DW = inst_buffer_pkg::DECODE_WIDTH
) ();
    import inst_buffer_pkg::*;

    localparam int NUM_W = $clog2(FW + 1);

    logic                          in_en;
    logic [NUM_W-1:0]              in_num;
    logic [FW-1:0][INST_WIDTH-1:0] in_inst;
    logic [FW-1:0][XLEN-1:0]       in_pc;
    logic                          in_ready;
    logic [DW-1:0]                 out_valid;
    logic [DW-1:0][INST_WIDTH-1:0] out_inst;
    logic [DW-1:0][XLEN-1:0]       out_pc;
    logic                          out_ready;

    modport master (
        output in_en, in_num, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc
    );

    modport slave (
        input  in_en, in_num, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc
    );

endinterface

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular instruction buffer between fetch groups and decode slots
module inst_buffer #(
    parameter int FETCH_WIDTH  = inst_buffer_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = inst_buffer_pkg::DECODE_WIDTH,
    parameter int DEPTH        = inst_buffer_pkg::IBUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    inst_buffer_if.slave       bus
);
    import inst_buffer_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ibuf_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             enq_fire, deq_fire;
    logic [CNT_W-1:0] enq_num, deq_num;

    always_comb begin
        enq_fire = bus.in_en && in_ready_q && !flush;
        deq_fire = bus.out_ready && !flush;
        enq_num  = enq_fire ? CNT_W'(bus.in_num) : '0;
        deq_num  = '0;
        if (deq_fire) begin
            deq_num = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_num);
            tail_d  = tail_q + PTR_W'(enq_num);
            count_d = count_q + enq_num - deq_num;
        end

        // Registered so fetch sees a ready that already accounts for this edge.
        in_ready_d = (CNT_W'(DEPTH) - count_d) >= CNT_W'(FETCH_WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq_fire && (i < int'(bus.in_num))) begin
                mem_q[tail_q + PTR_W'(i)].pc   <= bus.in_pc[i];
                mem_q[tail_q + PTR_W'(i)].inst <= bus.in_inst[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            bus.out_valid[i] = (CNT_W'(i) < count_q) && !flush;
            bus.out_inst[i]  = mem_q[head_q + PTR_W'(i)].inst;
            bus.out_pc[i]    = mem_q[head_q + PTR_W'(i)].pc;
        end
    end

    assign bus.in_ready = in_ready_q;

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - directed vector bench for inst_buffer
module tb_inst_buffer;

    logic clk;
    logic rst;
    logic flush;

    inst_buffer_if bus ();

    inst_buffer dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  num;
        logic        rdy;
        logic        fl;
        logic [31:0] base;
        logic [3:0]  exp_valid;
        logic [31:0] exp_pc0;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic add(input logic en, input logic [2:0] num, input logic rdy, input logic fl,
                       input logic [31:0] base, input logic [3:0] ev, input logic [31:0] epc,
                       input logic er);
        vec_t v;
        v.en = en; v.num = num; v.rdy = rdy; v.fl = fl; v.base = base;
        v.exp_valid = ev; v.exp_pc0 = epc; v.exp_ready = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [2:0] num, input logic rdy, input logic fl,
                         input logic [31:0] base);
        bus.in_en     = en;
        bus.in_num    = num;
        bus.out_ready = rdy;
        flush         = fl;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc[i]   = base + 32'(4 * i);
            bus.in_inst[i] = inst_of(base + 32'(4 * i));
        end
        @(posedge clk);
        #1;
        bus.in_en     = 1'b0;
        bus.in_num    = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_en     = 1'b0;
        bus.in_num    = '0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        check("reset_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //   en num rdy fl  base        valid    pc0          ready
        add(1'b0, 3'd0, 1'b0, 1'b0, 32'h000, 4'b0000, 32'h000, 1'b1);
        add(1'b1, 3'd3, 1'b0, 1'b0, 32'h100, 4'b0111, 32'h100, 1'b1);
        add(1'b1, 3'd0, 1'b0, 1'b0, 32'h900, 4'b0111, 32'h100, 1'b1);
        add(1'b1, 3'd4, 1'b1, 1'b1, 32'h900, 4'b0000, 32'h000, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'h200, 4'b1111, 32'h200, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'h300, 4'b1111, 32'h200, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'h400, 4'b1111, 32'h200, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'h500, 4'b1111, 32'h200, 1'b0);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'h600, 4'b1111, 32'h200, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b0, 32'h000, 4'b1111, 32'h300, 1'b1);
        add(1'b0, 3'd0, 1'b1, 1'b0, 32'h000, 4'b1111, 32'h400, 1'b1);
        add(1'b0, 3'd0, 1'b1, 1'b0, 32'h000, 4'b1111, 32'h500, 1'b1);
        add(1'b0, 3'd0, 1'b1, 1'b0, 32'h000, 4'b0000, 32'h000, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'h700, 4'b1111, 32'h700, 1'b1);
        add(1'b1, 3'd2, 1'b0, 1'b0, 32'h800, 4'b1111, 32'h700, 1'b1);
        add(1'b1, 3'd4, 1'b1, 1'b0, 32'hA00, 4'b1111, 32'h800, 1'b1);
        add(1'b0, 3'd0, 1'b1, 1'b0, 32'h000, 4'b0011, 32'hA08, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'hB00, 4'b1111, 32'hA08, 1'b1);
        add(1'b1, 3'd4, 1'b0, 1'b0, 32'hC00, 4'b1111, 32'hA08, 1'b1);
        add(1'b1, 3'd4, 1'b1, 1'b1, 32'hD00, 4'b0000, 32'h000, 1'b1);
        add(1'b0, 3'd0, 1'b1, 1'b0, 32'h000, 4'b0000, 32'h000, 1'b1);
        add(1'b1, 3'd1, 1'b0, 1'b0, 32'hE00, 4'b0001, 32'hE00, 1'b1);

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].num, vecs[k].rdy, vecs[k].fl, vecs[k].base);
            check($sformatf("v%0d_valid", k), 32'(bus.out_valid), 32'(vecs[k].exp_valid));
            check($sformatf("v%0d_ready", k), 32'(bus.in_ready), 32'(vecs[k].exp_ready));
            if (vecs[k].exp_valid[0]) begin
                check($sformatf("v%0d_pc0", k), bus.out_pc[0], vecs[k].exp_pc0);
                check($sformatf("v%0d_inst0", k), bus.out_inst[0], inst_of(vecs[k].exp_pc0));
            end
        end

        // Walk head to 14 with an empty buffer, then straddle the wrap point.
        drive(1'b0, 3'd0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd4, 1'b0, 1'b0, 32'h1000 + 32'(k * 16));
            drive(1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        end
        drive(1'b1, 3'd2, 1'b0, 1'b0, 32'h1100);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        check("wrap_empty", 32'(bus.out_valid), 32'h0);
        drive(1'b1, 3'd4, 1'b0, 1'b0, 32'h2000);
        check("wrap_valid", 32'(bus.out_valid), 32'hF);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_pc%0d", i), bus.out_pc[i], 32'h2000 + 32'(4 * i));
            check($sformatf("wrap_inst%0d", i), bus.out_inst[i], inst_of(32'h2000 + 32'(4 * i)));
        end
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h3000);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        check("wrap_tail_valid", 32'(bus.out_valid), 32'h1);
        check("wrap_tail_pc", bus.out_pc[0], 32'h3000);

        // Asynchronous reset in the middle of a cycle with eight entries held.
        drive(1'b0, 3'd0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 3'd4, 1'b0, 1'b0, 32'h5000);
        drive(1'b1, 3'd4, 1'b0, 1'b0, 32'h5010);
        check("prerst_valid", 32'(bus.out_valid), 32'hF);
        check("prerst_pc0", bus.out_pc[0], 32'h5000);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h6000);
        check("postrst_valid", 32'(bus.out_valid), 32'h1);
        check("postrst_pc0", bus.out_pc[0], 32'h6000);
        check("postrst_inst0", bus.out_inst[0], inst_of(32'h6000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
